switch_port_ctrl: RTL and testbench
===================================

# switch_port_ctrl

Parametrised input-port controller for an N-port packet switch: buffers incoming packets in a local FIFO, classifies each head packet by its target mask, requests the targeted output arbiters, and transmits once every targeted output has granted. One instance sits behind each switch input; outputs go to the per-output arbiters and the shared crossbar bus.

## Interface
- NUM_PORTS, 4: switch port count; width of source/target masks.
- PAYLOAD_WIDTH, 8: packet data field width.
- DEPTH, 8: input FIFO entries; power of two, ≥2.
- PORT_ID, 0: this port's index; the legal source mask is 1<<PORT_ID.
- TIMEOUT_CYCLES, 64: ARB_WAIT limit; exists only with SWITCH_ARB_TIMEOUT_EN.
- PKT_W is a derived constant: 2*NUM_PORTS+PAYLOAD_WIDTH. Packet layout, MSB first: {source[NUM_PORTS], target[NUM_PORTS], data[PAYLOAD_WIDTH]}.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input packet valid.
- in_ready  out  1  equals !full.
- in_pkt  in  PKT_W  input packet.
- req  out  NUM_PORTS  arbiter requests; equals the held target while in ARB_WAIT, else 0.
- gnt  in  NUM_PORTS  per-output grant; arbiters hold a grant while its request is held.
- out_valid  out  NUM_PORTS  equals the held target for the one TRANSMIT cycle.
- out_pkt  out  PKT_W  held packet; always driven from the holding register.
- err_drop  out  1  one-cycle pulse when a packet is discarded.
- ptype  out  2  p_type of the held packet.
- fifo_count  out  $clog2(DEPTH+1)  FIFO occupancy.

## Operation
- Push: a packet is pushed when in_valid && in_ready. No push occurs when the FIFO is full, even if a pop happens in the same cycle.
- Classification of the held packet:
  - ERR: target==0, or source != 1<<PORT_ID.
  - BDP: target all ones.
  - SDP: popcount(target)==1.
  - MDP: any other mask.
- FSM states: IDLE, ROUTE, ARB_WAIT, TRANSMIT (encoded 00/01/10/11).
- IDLE: when the FIFO is non-empty, pop the head into the holding register and go to ROUTE.
- ROUTE:
  - ERR: pulse err_drop; go to IDLE.
  - Otherwise: clear gnt_seen; go to ARB_WAIT.
- ARB_WAIT:
  - gnt_seen |= gnt & target. Grant bits outside target are ignored.
  - When (gnt_seen | (gnt & target)) == target, go to TRANSMIT. Partial grants accumulate across cycles.
- TRANSMIT: out_valid = target for exactly one cycle.
  - FIFO non-empty: pop and go directly to ROUTE (back-to-back packets).
  - FIFO empty: go to IDLE.
- Reset mid-operation discards the held packet and all FIFO contents. Nothing is emitted.

## Timing
- Reset values: in_ready=1, req=0, out_valid=0, out_pkt=0, err_drop=0, ptype=ERR, fifo_count=0, state=IDLE.
- All outputs decode from registered state; in_ready decodes from registered count. There is no combinational path from inputs to outputs.
- Minimum latency, with the write at edge 0 into an empty, idle port:
  - Edge 1: enter ROUTE (pop).
  - Edge 2: enter ARB_WAIT; req is asserted in the following cycle.
  - Edge 3 (if gnt is already high): enter TRANSMIT.
  - out_valid is high for the cycle after edge 3.
- Sustained throughput with immediate grants is one packet per 3 cycles (ROUTE, ARB_WAIT, TRANSMIT).
- FIFO pointers wrap modulo DEPTH. Simultaneous push and pop leaves the count unchanged.

## Configuration
- SWITCH_ARB_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ARB_WAIT.
  - If ARB_WAIT lasts TIMEOUT_CYCLES cycles without completion: release req, pulse err_drop, discard the packet, go to IDLE.
  - This breaks multi-destination deadlock.
- Undefined: ARB_WAIT waits indefinitely. The counter and TIMEOUT_CYCLES are absent.

## Structure
- Shared package holds:
  - the state enum and p_type enum;
  - a popcount function over NUM_PORTS;
  - default constants for data width, address width and depth.
- Packet fields are sliced by parameter; the package does not contain a fixed-width struct.
- Sub-module pkt_fifo: synchronous FIFO parametrised by width and depth, providing count, full and empty.

## Test plan
- SDP target 4'b0100, gnt=4'b0100 held → out_valid=4'b0100 exactly 3 cycles after the write edge; out_pkt matches; ptype=SDP.
- MDP target 4'b1010; gnt bit 1 in cycle 1, bit 3 in cycle 4 (bit 1 dropped) → TRANSMIT after cycle 4; out_valid=4'b1010 once.
- target=0, then source=4'b0010 with PORT_ID=0 → two err_drop pulses, no out_valid, FIFO drains.
- Push 9 packets with gnt=0 → in_ready=0 at count 8, ninth rejected. Release gnt=4'b1111 → 8 BDP transmits at a 3-cycle spacing, in order.
- With SWITCH_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, gnt=0 → err_drop 16 cycles after ARB_WAIT entry; req returns to 0.
- Assert rst_n=0 during ARB_WAIT → req=0, fifo_count=0, state=IDLE immediately; no out_valid after release.

Source files
------------

// File: rtl/switch_port_ctrl_pkg.sv
// Shared types and helpers for the switch input-port controller.
package switch_port_ctrl_pkg;

  localparam int DEF_PAYLOAD_WIDTH = 8;
  localparam int DEF_DEPTH         = 8;
  localparam int DEF_ADDR_W        = $clog2(DEF_DEPTH);
  localparam int MAX_PORTS         = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ROUTE    = 2'b01,
    ST_ARB_WAIT = 2'b10,
    ST_TRANSMIT = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    PT_ERR = 2'd0,
    PT_SDP = 2'd1,
    PT_MDP = 2'd2,
    PT_BDP = 2'd3
  } ptype_e;

  // Number of set bits in a port mask (masks are zero-extended to MAX_PORTS).
  function automatic int unsigned popcount(input logic [MAX_PORTS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      n = n + {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/switch_port_ctrl_pkt_fifo.sv
// Synchronous packet FIFO with occupancy count. Pushes are refused while
// full (even alongside a pop); pops are refused while empty.
module switch_port_ctrl_pkt_fifo
  import switch_port_ctrl_pkg::*;
#(
  parameter int WIDTH = 2 * 4 + DEF_PAYLOAD_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and count next-state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage array: written on accepted push, never reset (contents are gated by count).
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/switch_port_ctrl.sv
// Input-port controller for an N-port packet switch: buffers packets, classifies
// the head packet, requests the targeted output arbiters and transmits once all
// targets have granted. Optional macro SWITCH_ARB_TIMEOUT_EN adds an ARB_WAIT
// timeout (TIMEOUT_CYCLES) that drops a packet whose grants never complete.
//
// state    | meaning
// IDLE     | nothing held; pop the FIFO head when available
// ROUTE    | held packet classified; drop ERR, else clear grant record
// ARB_WAIT | req = target; accumulate grants until every target bit seen
// TRANSMIT | out_valid = target for one cycle; pop next packet if present
module switch_port_ctrl
  import switch_port_ctrl_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int PAYLOAD_WIDTH  = DEF_PAYLOAD_WIDTH,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int PORT_ID        = 0,
`ifdef SWITCH_ARB_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 64,
`endif
  localparam int PKT_W         = 2 * NUM_PORTS + PAYLOAD_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PKT_W-1:0]           in_pkt,
  output logic [NUM_PORTS-1:0]       req,
  input  logic [NUM_PORTS-1:0]       gnt,
  output logic [NUM_PORTS-1:0]       out_valid,
  output logic [PKT_W-1:0]           out_pkt,
  output logic                       err_drop,
  output logic [1:0]                 ptype,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam logic [NUM_PORTS-1:0] SRC_MASK = NUM_PORTS'(1) << PORT_ID;

  state_e                 state_q, state_d;
  logic [PKT_W-1:0]       hold_q, hold_d;
  logic [NUM_PORTS-1:0]   gnt_seen_q, gnt_seen_d;
  logic                   err_drop_q, err_drop_d;
  logic                   fifo_pop, fifo_push, fifo_full, fifo_empty;
  logic [PKT_W-1:0]       fifo_rdata;
  logic [NUM_PORTS-1:0]   hold_src, hold_tgt;
  logic                   all_granted, tmo_hit;
  ptype_e                 ptype_w;

  assign fifo_push = in_valid && !fifo_full;

  switch_port_ctrl_pkt_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (in_pkt),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign hold_src    = hold_q[PKT_W-1 -: NUM_PORTS];
  assign hold_tgt    = hold_q[PAYLOAD_WIDTH +: NUM_PORTS];
  assign all_granted = ((gnt_seen_q | (gnt & hold_tgt)) == hold_tgt);

  // Classify the held packet by its source and target masks.
  always_comb begin
    if (hold_tgt == '0 || hold_src != SRC_MASK) begin
      ptype_w = PT_ERR;
    end else if (hold_tgt == '1) begin
      ptype_w = PT_BDP;
    end else if (popcount(MAX_PORTS'(hold_tgt)) == 1) begin
      ptype_w = PT_SDP;
    end else begin
      ptype_w = PT_MDP;
    end
  end

`ifdef SWITCH_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Wait timer: cleared in ROUTE so it starts at zero on ARB_WAIT entry.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ST_ROUTE) begin
      tmo_cnt_d = '0;
    end else if (state_q == ST_ARB_WAIT) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end
  end

  // Wait timer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State, holding register, grant record and drop pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      gnt_seen_q <= '0;
      err_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      gnt_seen_q <= gnt_seen_d;
      err_drop_q <= err_drop_d;
    end
  end

  // Next-state logic, FIFO pop and grant accumulation.
  always_comb begin
    state_d    = state_q;
    gnt_seen_d = gnt_seen_q;
    err_drop_d = 1'b0;
    fifo_pop   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_ROUTE;
        end
      end
      ST_ROUTE: begin
        if (ptype_w == PT_ERR) begin
          err_drop_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          gnt_seen_d = '0;
          state_d    = ST_ARB_WAIT;
        end
      end
      ST_ARB_WAIT: begin
        gnt_seen_d = gnt_seen_q | (gnt & hold_tgt);
        if (all_granted) begin
          state_d = ST_TRANSMIT;
        end else if (tmo_hit) begin
          err_drop_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_TRANSMIT: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_ROUTE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    hold_d = fifo_pop ? fifo_rdata : hold_q;
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    in_ready  = !fifo_full;
    req       = (state_q == ST_ARB_WAIT) ? hold_tgt : '0;
    out_valid = (state_q == ST_TRANSMIT) ? hold_tgt : '0;
    out_pkt   = hold_q;
    err_drop  = err_drop_q;
    ptype     = ptype_w;
  end

endmodule

// File: tb/tb_switch_port_ctrl.sv
module tb_switch_port_ctrl;
  import switch_port_ctrl_pkg::*;

  localparam int NP    = 4;
  localparam int PW    = 8;
  localparam int DP    = 8;
  localparam int PKT_W = 2 * NP + PW;
  localparam int TMO   = 16;
  localparam logic [NP-1:0] SRC_OK = 4'b0001;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [PKT_W-1:0] in_pkt;
  logic [NP-1:0]    req;
  logic [NP-1:0]    gnt;
  logic [NP-1:0]    out_valid;
  logic [PKT_W-1:0] out_pkt;
  logic             err_drop;
  logic [1:0]       ptype;
  logic [3:0]       fifo_count;

  int n_vec  = 0;
  int n_miss = 0;

  switch_port_ctrl #(
    .NUM_PORTS     (NP),
    .PAYLOAD_WIDTH (PW),
    .DEPTH         (DP),
`ifdef SWITCH_ARB_TIMEOUT_EN
    .TIMEOUT_CYCLES(TMO),
`endif
    .PORT_ID       (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pkt     (in_pkt),
    .req        (req),
    .gnt        (gnt),
    .out_valid  (out_valid),
    .out_pkt    (out_pkt),
    .err_drop   (err_drop),
    .ptype      (ptype),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] src;
    logic [3:0] tgt;
    logic [7:0] data;
    logic [3:0] gnt;
    logic       exp_tx;
    logic [1:0] exp_ptype;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference classification straight from the packet-type rules.
  function automatic logic [1:0] ref_ptype(input logic [PKT_W-1:0] p);
    logic [3:0] s;
    logic [3:0] t;
    s = p[15:12];
    t = p[11:8];
    if (t == 4'h0 || s != SRC_OK) return PT_ERR;
    if (t == 4'hF) return PT_BDP;
    if ($countones(t) == 1) return PT_SDP;
    return PT_MDP;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t             tbl[8];
  logic [PKT_W-1:0] pkt, blocker;
  int               ov_cyc, ov_n, err_n, first_req, first_err, exp_cnt, n_ev;
  logic [3:0]       ov_val;
  logic [PKT_W-1:0] ov_pkt;
  logic [1:0]       pt1;
  int               ev_cyc[16];
  logic [3:0]       ev_val[16];
  logic [PKT_W-1:0] ev_pkt[16];
  logic [PKT_W:0]   sb_q[$];
  logic [PKT_W:0]   head;
  logic [3:0]       prev_req, acc, exp_ov, head_tgt;
  int               arb_len;
  logic             exp_tmo;

  initial begin
    tbl[0] = '{4'b0001, 4'b0100, 8'hA5, 4'b0100, 1'b1, PT_SDP};
    tbl[1] = '{4'b0001, 4'b1111, 8'h3C, 4'b1111, 1'b1, PT_BDP};
    tbl[2] = '{4'b0001, 4'b1010, 8'h77, 4'b1010, 1'b1, PT_MDP};
    tbl[3] = '{4'b0001, 4'b0001, 8'h01, 4'b1111, 1'b1, PT_SDP};
    tbl[4] = '{4'b0001, 4'b0000, 8'h11, 4'b1111, 1'b0, PT_ERR};
    tbl[5] = '{4'b0010, 4'b0100, 8'h22, 4'b1111, 1'b0, PT_ERR};
    tbl[6] = '{4'b0001, 4'b0111, 8'h99, 4'b1111, 1'b1, PT_MDP};
    tbl[7] = '{4'b0011, 4'b0100, 8'h5B, 4'b0100, 1'b0, PT_ERR};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_pkt   = '0;
    gnt      = '0;
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_req", req, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pkt", out_pkt, 0);
    check("rst_err_drop", err_drop, 0);
    check("rst_ptype", ptype, PT_ERR);
    check("rst_fifo_count", fifo_count, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single packets into an idle, empty port with a constant grant pattern.
    for (int v = 0; v < 8; v++) begin
      pkt      = {tbl[v].src, tbl[v].tgt, tbl[v].data};
      gnt      = tbl[v].gnt;
      in_pkt   = pkt;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      ov_cyc = -1; ov_n = 0; err_n = 0; ov_val = '0; ov_pkt = '0; pt1 = '0;
      for (int c = 1; c <= 8; c++) begin
        tick();
        if (c == 1) pt1 = ptype;
        if (out_valid != 0) begin
          ov_n++;
          if (ov_cyc < 0) begin
            ov_cyc = c;
            ov_val = out_valid;
            ov_pkt = out_pkt;
          end
        end
        if (err_drop) err_n++;
      end
      gnt = '0;
      check($sformatf("vec%0d_ptype", v), pt1, tbl[v].exp_ptype);
      if (tbl[v].exp_tx) begin
        check($sformatf("vec%0d_latency", v), ov_cyc, 3);
        check($sformatf("vec%0d_out_valid", v), ov_val, tbl[v].tgt);
        check($sformatf("vec%0d_out_pkt", v), ov_pkt, pkt);
        check($sformatf("vec%0d_tx_count", v), ov_n, 1);
        check($sformatf("vec%0d_no_drop", v), err_n, 0);
      end else begin
        check($sformatf("vec%0d_no_tx", v), ov_n, 0);
        check($sformatf("vec%0d_drop_count", v), err_n, 1);
      end
      check($sformatf("vec%0d_drained", v), fifo_count, 0);
    end

    // Partial grants accumulate: bit 1 in the first ARB_WAIT cycle, bit 3 in the fourth.
    pkt      = {4'b0001, 4'b1010, 8'h5A};
    gnt      = '0;
    in_pkt   = pkt;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ov_cyc = -1; ov_n = 0; ov_val = '0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 3) check("mdp_req", req, 4'b1010);
      if (out_valid != 0) begin
        ov_n++;
        if (ov_cyc < 0) begin
          ov_cyc = c;
          ov_val = out_valid;
        end
      end
      gnt = (c == 2) ? 4'b0010 : (c == 5) ? 4'b1000 : 4'b0000;
    end
    check("mdp_tx_cycle", ov_cyc, 6);
    check("mdp_out_valid", ov_val, 4'b1010);
    check("mdp_tx_count", ov_n, 1);

    // Fill the FIFO behind a blocked packet, then release all grants.
    blocker  = {4'b0001, 4'b0100, 8'hEE};
    gnt      = '0;
    in_pkt   = blocker;
    in_valid = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      in_pkt   = {4'b0001, 4'b1111, 8'(i)};
      in_valid = 1'b1;
      tick();
      exp_cnt = (i < 8) ? i + 1 : 8;
      check($sformatf("fill%0d_count", i), fifo_count, exp_cnt);
      check($sformatf("fill%0d_in_ready", i), in_ready, (exp_cnt != 8));
    end
    in_valid = 1'b0;
    check("fill_blocker_req", req, 4'b0100);
    gnt  = 4'b1111;
    n_ev = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (out_valid != 0 && n_ev < 16) begin
        ev_cyc[n_ev] = c;
        ev_val[n_ev] = out_valid;
        ev_pkt[n_ev] = out_pkt;
        n_ev++;
      end
    end
    gnt = '0;
    check("fill_tx_total", n_ev, 9);
    if (n_ev == 9) begin
      check("fill_blocker_tgt", ev_val[0], 4'b0100);
      check("fill_blocker_pkt", ev_pkt[0], blocker);
      for (int k = 1; k < 9; k++) begin
        check($sformatf("fill_bdp%0d_tgt", k - 1), ev_val[k], 4'b1111);
        check($sformatf("fill_bdp%0d_pkt", k - 1), ev_pkt[k], {4'b0001, 4'b1111, 8'(k - 1)});
        check($sformatf("fill_bdp%0d_spacing", k - 1), ev_cyc[k] - ev_cyc[k-1], 3);
      end
    end
    check("fill_drained", fifo_count, 0);

    // Reset while waiting for grants discards everything.
    gnt      = '0;
    in_pkt   = {4'b0001, 4'b0100, 8'h33};
    in_valid = 1'b1;
    tick();
    in_pkt = {4'b0001, 4'b0010, 8'h44};
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (req != 0) break;
      tick();
    end
    check("rstarb_reached", req, 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstarb_req", req, 0);
    check("rstarb_count", fifo_count, 0);
    check("rstarb_in_ready", in_ready, 1);
    check("rstarb_out_valid", out_valid, 0);
    check("rstarb_out_pkt", out_pkt, 0);
    tick();
    rst_n = 1'b1;
    gnt   = 4'b1111;
    ov_n = 0; err_n = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (out_valid != 0) ov_n++;
      if (err_drop) err_n++;
    end
    gnt = '0;
    check("rstarb_no_tx", ov_n, 0);
    check("rstarb_no_drop", err_n, 0);

    // Grant never arrives: timeout drop when enabled, indefinite wait otherwise.
    pkt      = {4'b0001, 4'b0010, 8'h66};
    in_pkt   = pkt;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    first_req = -1; first_err = -1; ov_n = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (req != 0 && first_req < 0) first_req = c;
      if (err_drop && first_err < 0) first_err = c;
      if (out_valid != 0) ov_n++;
    end
    check("wait_req_start", first_req, 2);
    check("wait_no_tx", ov_n, 0);
`ifdef SWITCH_ARB_TIMEOUT_EN
    check("tmo_drop_cycle", first_err, 2 + TMO);
    check("tmo_req_released", req, 0);
`else
    check("wait_no_drop", first_err, -1);
    check("wait_req_held", req, 4'b0010);
    gnt = 4'b0010;
    tick();
    check("wait_release_tx", out_valid, 4'b0010);
    check("wait_release_pkt", out_pkt, pkt);
    gnt = '0;
    tick();
`endif
    tick();

    // Randomised traffic against a transaction-level scoreboard.
    prev_req = '0;
    acc      = '0;
    arb_len  = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      exp_ov  = '0;
      exp_tmo = 1'b0;
      if (prev_req != 0) begin
        if ((acc & prev_req) == prev_req) exp_ov = prev_req;
`ifdef SWITCH_ARB_TIMEOUT_EN
        else if (arb_len == TMO) exp_tmo = 1'b1;
`endif
      end
      check("rnd_out_valid", out_valid, exp_ov);
      if (out_valid != 0) begin
        check("rnd_tx_has_pkt", (sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          head = sb_q.pop_front();
          check("rnd_tx_kind", head[PKT_W], 0);
          check("rnd_tx_pkt", out_pkt, head[PKT_W-1:0]);
        end
      end
`ifdef SWITCH_ARB_TIMEOUT_EN
      if (exp_tmo) check("rnd_tmo_drop", err_drop, 1);
`endif
      if (err_drop) begin
        check("rnd_drop_has_pkt", (sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          head = sb_q.pop_front();
          if (!exp_tmo) check("rnd_drop_kind", head[PKT_W], 1);
        end
      end
      if (req != 0) begin
        head_tgt = (sb_q.size() > 0) ? sb_q[0][11:8] : 4'h0;
        check("rnd_req_tgt", req, head_tgt);
      end
      check("rnd_in_ready", in_ready, (fifo_count != 4'(DP)));

      in_valid = (cyc < 500) && ($urandom_range(0, 2) != 0);
      pkt      = {(($urandom_range(0, 7) == 0) ? 4'($urandom) : SRC_OK), 4'($urandom), 8'($urandom)};
      in_pkt   = pkt;
      gnt      = (cyc < 500) ? 4'($urandom) : 4'hF;
      if (in_valid && in_ready) sb_q.push_back({(ref_ptype(pkt) == PT_ERR), pkt});
      if (req != 0) begin
        if (prev_req == 0) begin
          acc     = '0;
          arb_len = 0;
        end
        acc = acc | (gnt & req);
        arb_len++;
      end
      prev_req = req;
      tick();
    end
    in_valid = 1'b0;
    gnt      = '0;
    check("rnd_sb_empty", sb_q.size(), 0);
    check("rnd_fifo_empty", fifo_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
